// File: rtl/rca_seq_ctrl.sv
// Sequential ripple-carry adder controller: steps one 4-bit slice per cycle
// through an external combinational nibble adder and assembles the sum.
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [3:0]           nib_a,
    output logic [3:0]           nib_b,
    output logic                 nib_cin,
    input  logic [3:0]           nib_s,
    input  logic                 nib_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  s_r;
    logic [W-1:0]  s_merged;
    logic [KW-1:0] k;
    logic          cy;
    logic          accept;
    logic          last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        nib_a    = 4'h0;
        nib_b    = 4'h0;
        nib_cin  = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        s_merged = s_r;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                nib_a    = a_r[{k, 2'b00} +: 4];
                nib_b    = b_r[{k, 2'b00} +: 4];
                nib_cin  = cy;
                last     = (k == KW'(NIBBLES - 1));
                s_merged[{k, 2'b00} +: 4] = nib_s;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // sum/cout are only written on the final slice, so they hold across a new op
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            s_r  <= '0;
            k    <= '0;
            cy   <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= b;
            cy  <= cin;
            k   <= '0;
        end else if (state == RUN) begin
            s_r <= s_merged;
            cy  <= nib_cout;
            k   <= last ? '0 : k + 1'b1;
            if (last) begin
                sum  <= s_merged;
                cout <= nib_cout;
            end
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with a behavioural nibble adder.
module tb_rca_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   nib_a;
    logic [3:0]   nib_b;
    logic         nib_cin;
    logic [3:0]   nib_s;
    logic         nib_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int pass_cnt = 0;
    int total    = 0;

    logic [3:0] seen_a   [8];
    logic [3:0] seen_b   [8];
    logic       seen_cin [8];
    int         busy_cyc;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    assign {nib_cout, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'h0, nib_cin};

    rca_seq_ctrl #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .nib_a    (nib_a),
        .nib_b    (nib_b),
        .nib_cin  (nib_cin),
        .nib_s    (nib_s),
        .nib_cout (nib_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Pulse start, record the slices presented while busy, then check done.
    task automatic run_op(input string name, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic vc,
                          input logic [W-1:0] es, input logic ec);
        logic [3:0] sa;
        logic [3:0] sb;
        logic       c;
        logic [4:0] t;
        logic       slices_ok;
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        while (busy && busy_cyc < 20) begin
            if (busy_cyc < 8) begin
                seen_a[busy_cyc]   = nib_a;
                seen_b[busy_cyc]   = nib_b;
                seen_cin[busy_cyc] = nib_cin;
            end
            busy_cyc++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, busy_cyc, N);
        chk({name, " done"}, done, 1'b1);
        chk({name, " sum"}, sum, es);
        chk({name, " cout"}, cout, ec);
        slices_ok = 1'b1;
        c = vc;
        for (int i = 0; i < N; i++) begin
            sa = va[4*i +: 4];
            sb = vb[4*i +: 4];
            if (seen_a[i] !== sa || seen_b[i] !== sb || seen_cin[i] !== c)
                slices_ok = 1'b0;
            t = {1'b0, sa} + {1'b0, sb} + {4'h0, c};
            c = t[4];
        end
        chk({name, " slices"}, slices_ok, 1'b1);
        @(negedge clk);
        chk({name, " done_pulse_end"}, done, 1'b0);
        chk({name, " idle_nib_a"}, nib_a, 4'h0);
    endtask

    initial begin
        logic [15:0] na_seq;
        logic [3:0]  cin_seq;
        int          seq_err;
        int          n_done;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
        vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};

        rst   = 1'b1;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset sum", sum, 16'h0000);
        chk("reset cout", cout, 1'b0);
        chk("reset nib", {nib_a, nib_b, nib_cin}, 9'h0);
        start = 1'b0;
        rst   = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].cin, vecs[i].sum, vecs[i].cout);
            if (i == 1) begin
                cin_seq = {seen_cin[3], seen_cin[2], seen_cin[1], seen_cin[0]};
                chk("ffff_carry_chain", cin_seq, 4'b1110);
            end
            if (i == 2) begin
                na_seq = {seen_a[0], seen_a[1], seen_a[2], seen_a[3]};
                chk("1234_nib_a_seq", na_seq, 16'h4321);
            end
        end

        // start during RUN is ignored; sum holds the previous result meanwhile
        run_op("pre_hold", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0);
        @(negedge clk);
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold sum in run", sum, 16'h0030);
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                n_done++;
                chk("ignored_start sum", sum, 16'h0002);
                chk("ignored_start cout", cout, 1'b0);
            end
            @(negedge clk);
        end
        chk("ignored_start done_count", n_done, 1);

        // start held high: back-to-back ops, done every 5th cycle
        @(negedge clk);
        a       = 16'h8000;
        b       = 16'h8000;
        cin     = 1'b0;
        start   = 1'b1;
        seq_err = 0;
        n_done  = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done !== (c % 5 == 0) || busy !== (c % 5 != 0))
                seq_err++;
            if (done) begin
                n_done++;
                if (sum !== 16'h0000 || cout !== 1'b1)
                    seq_err++;
            end
        end
        start = 1'b0;
        chk("continuous errors", seq_err, 0);
        chk("continuous done_count", n_done, 3);
        repeat (6) @(negedge clk);

        // reset at k=2 aborts the op and clears the held result
        run_op("pre_abort", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort at k2 nib_a", nib_a, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort sum", sum, 16'h0000);
        chk("abort cout", cout, 1'b0);
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("abort no_done", n_done, 0);
        run_op("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to add a, b, cin; sampled only in IDLE or DONE.
REQ-005 a  input  W  operand A; captured on accepted start.
REQ-006 b  input  W  operand B; captured on accepted start.
REQ-007 cin  input  1  carry-in to nibble 0; captured on accepted start.
REQ-008 nib_a  output  4  A slice driven to the external 4-bit nibble adder.
REQ-009 nib_b  output  4  B slice driven to the external nibble adder.
REQ-010 nib_cin  output  1  carry driven to the external nibble adder.
REQ-011 nib_s  input  4  nibble sum returned by the external adder (combinational, same cycle).
REQ-012 nib_cout  input  1  nibble carry-out returned by the external adder.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse; sum and cout valid.
REQ-015 sum  output  W  result; held from done until the next accepted start completes.
REQ-016 cout  output  1  final carry-out; held like sum.

Function
REQ-017 FSM states IDLE, RUN, DONE; registered slice counter k, 0..NIBBLES-1; registered carry cy.
REQ-018 IDLE: start=1 -> latch a, b, cin into A_r, B_r, cy; k<=0; next RUN. start=0 -> stay IDLE.
REQ-019 RUN, combinational: nib_a=A_r[4k+3:4k], nib_b=B_r[4k+3:4k], nib_cin=cy.
REQ-020 RUN, each edge: S_r[4k+3:4k]<=nib_s; cy<=nib_cout; k<=k+1.
REQ-021 RUN with k=NIBBLES-1: after that edge, next state DONE; sum<=S_r with the final slice merged; cout<=nib_cout.
REQ-022 DONE lasts exactly one cycle with done=1; start=1 in DONE is accepted as in IDLE (back-to-back, next RUN); otherwise next IDLE.
REQ-023 Latency: start accepted at edge E0; busy=1 for cycles E0..E0+NIBBLES; done=1 in the cycle after edge E0+NIBBLES.
REQ-024 start in RUN is ignored; operand inputs in RUN do not affect the operation in flight.
REQ-025 Outside RUN, nib_a=0, nib_b=0, nib_cin=0.
REQ-026 sum and cout change only at the edge entering DONE; a new start does not disturb them until its own completion.
REQ-027 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1); no overflow flag.
REQ-028 Carry wrap: a carry out of slice k is consumed by slice k+1 in the next cycle only, never re-enters slice 0.

Reset
REQ-029 rst=1 at an edge -> state IDLE, k=0, cy=0, A_r=B_r=S_r=0, sum=0, cout=0, busy=0, done=0; rst has priority over start.
REQ-030 rst asserted mid-RUN aborts the operation; no done pulse; sum/cout read 0 afterwards.

Verification
REQ-031 NIBBLES=4: a=0x00FF, b=0x0001, cin=0, start 1 cycle -> busy 4 cycles, then done pulse with sum=0x0100, cout=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; nib_cin=1 in RUN cycles k=1,2,3.
REQ-033 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; nib_a sequence 4,3,2,1.
REQ-034 Second start with a=0xFFFF pulsed during RUN of op 0x0001+0x0001 -> ignored; single done with sum=0x0002.
REQ-035 start held high continuously with 0x8000+0x8000 -> done every 5th cycle, each with sum=0x0000, cout=1, no idle gap.
REQ-036 rst pulsed at k=2 of 0xFFFF+0xFFFF -> no done; next cycle busy=0, sum=0, cout=0; subsequent 0x0003+0x0004 -> sum=0x0007.
